// File: rtl/abs_share_pkg.sv
// abs_share_pkg
//   Shared definitions for the absolute-value sharing arbiter:
//     ABS_DW     - default operand/result width
//     rr_pick_t  - result of a round-robin search (found flag + winner index)
//     rr_pick()  - round-robin winner search over up to 16 requesters
//     abs_res_t  - contents of the registered result slot {data, id, ovf}
package abs_share_pkg;

   localparam int ABS_DW  = 32;
   localparam int MAX_REQ = 16;

   typedef struct packed {
      logic       found;
      logic [3:0] idx;
   } rr_pick_t;

   typedef struct packed {
      logic [ABS_DW-1:0] data;
      logic [3:0]        id;
      logic              ovf;
   } abs_res_t;

   // Round-robin search: first set bit of valid at or after ptr, wrapping at num.
   // Offsets are scanned from high to low so the smallest offset is the last
   // (and therefore winning) assignment.
   function automatic rr_pick_t rr_pick(input logic [15:0] valid,
                                        input logic [4:0]  num,
                                        input logic [3:0]  ptr);
      rr_pick_t   res;
      logic [4:0] off;
      logic [4:0] k;
      res = '0;
      for (int i = MAX_REQ - 1; i >= 0; i--) begin
         off = 5'(i);
         k   = {1'b0, ptr} + off;
         if (k >= num) begin
            k = k - num;
         end else begin
            k = k;
         end
         if ((off < num) && valid[k[3:0]]) begin
            res.found = 1'b1;
            res.idx   = k[3:0];
         end else begin
            res = res;
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/abs_dp.sv
// abs_dp
//   Purely combinational two's-complement absolute value.
//   Ports:
//     x_i      in  DW  operand
//     sat_en_i in  1   1: the most negative operand saturates to the maximum
//                      positive value; 0: it wraps to itself
//     y_o      out DW  |x|
//     ovf_o    out 1   operand was the most negative value
module abs_dp
   import abs_share_pkg::*;
#(
   parameter int DW = ABS_DW
) (
   input  logic [DW-1:0] x_i,
   input  logic          sat_en_i,
   output logic [DW-1:0] y_o,
   output logic          ovf_o
);

   localparam logic [DW-1:0] MIN_V = {1'b1, {(DW-1){1'b0}}};
   localparam logic [DW-1:0] MAX_V = {1'b0, {(DW-1){1'b1}}};

   logic          neg_s;
   logic [DW-1:0] wrap_s;

   assign neg_s  = x_i[DW-1];
   // Conditional one's complement plus the sign bit as carry-in.
   assign wrap_s = (x_i ^ {DW{neg_s}}) + {{(DW-1){1'b0}}, neg_s};
   assign ovf_o  = (x_i == MIN_V);
   assign y_o    = (sat_en_i && ovf_o) ? MAX_V : wrap_s;

endmodule

// File: rtl/abs_share_arbiter.sv
// abs_share_arbiter
//   Shares one absolute-value datapath between NUM_REQ requesters using a
//   round-robin arbiter and a single registered, tagged result slot.
//   Build option: define ABS_SHARE_SAT_EN to saturate the most negative
//   operand to the maximum positive value instead of wrapping.
//   Ports:
//     clk, rst     clock, asynchronous active-high reset
//     req_valid_i  NUM_REQ     per-requester operand valid
//     req_data_i   NUM_REQ*DW  packed operands, requester k at [k*DW +: DW]
//     req_ready_o  NUM_REQ     per-requester accept (one-hot or zero)
//     res_valid_o  1           result slot occupied
//     res_ready_i  1           consumer accepts result
//     res_data_o   DW          |operand|
//     res_id_o     IDW         requester that produced res_data_o
//     res_ovf_o    1           operand was the most negative value
module abs_share_arbiter
   import abs_share_pkg::*;
#(
   parameter  int NUM_REQ = 4,
   parameter  int DW      = ABS_DW,
   localparam int IDW     = $clog2(NUM_REQ)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_REQ-1:0]    req_valid_i,
   input  logic [NUM_REQ*DW-1:0] req_data_i,
   output logic [NUM_REQ-1:0]    req_ready_o,
   output logic                  res_valid_o,
   input  logic                  res_ready_i,
   output logic [DW-1:0]         res_data_o,
   output logic [IDW-1:0]        res_id_o,
   output logic                  res_ovf_o
);

`ifdef ABS_SHARE_SAT_EN
   localparam logic SAT_EN = 1'b1;
`else
   localparam logic SAT_EN = 1'b0;
`endif

   abs_res_t       res_q, res_d;
   logic           valid_q, valid_d;
   logic [IDW-1:0] ptr_q, ptr_d;

   rr_pick_t       pick_s;
   logic [IDW-1:0] g_s;
   logic           free_s;
   logic           grant_s;
   logic [DW-1:0]  op_s;
   logic [DW-1:0]  dp_y_s;
   logic           dp_ovf_s;
   logic           unused_s;

   assign pick_s  = rr_pick(16'(req_valid_i), 5'(NUM_REQ), 4'(ptr_q));
   assign g_s     = pick_s.idx[IDW-1:0];
   assign free_s  = !valid_q || res_ready_i;
   // The winner is always a valid requester, so a grant is also a transfer.
   assign grant_s = free_s && pick_s.found && !rst;
   assign op_s    = req_data_i[g_s*DW +: DW];

   assign req_ready_o = grant_s ? (NUM_REQ'(1) << g_s) : '0;

   abs_dp #(.DW(DW)) u_dp (
      .x_i      (op_s),
      .sat_en_i (SAT_EN),
      .y_o      (dp_y_s),
      .ovf_o    (dp_ovf_s)
   );

   // Next-state for the result slot and the round-robin pointer.
   always_comb begin
      res_d   = res_q;
      valid_d = valid_q;
      ptr_d   = ptr_q;
      if (grant_s) begin
         res_d.data = ABS_DW'(dp_y_s);
         res_d.id   = 4'(g_s);
         res_d.ovf  = dp_ovf_s;
         valid_d    = 1'b1;
         if (g_s == IDW'(NUM_REQ - 1)) begin
            ptr_d = '0;
         end else begin
            ptr_d = g_s + IDW'(1);
         end
      end else if (valid_q && res_ready_i) begin
         // Drain: payload is retained, only the occupancy flag clears.
         valid_d = 1'b0;
      end else begin
         valid_d = valid_q;
      end
   end

   // Result slot and pointer registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         res_q   <= '0;
         valid_q <= 1'b0;
         ptr_q   <= '0;
      end else begin
         res_q   <= res_d;
         valid_q <= valid_d;
         ptr_q   <= ptr_d;
      end
   end

   assign res_valid_o = valid_q;
   assign res_data_o  = DW'(res_q.data);
   assign res_id_o    = res_q.id[IDW-1:0];
   assign res_ovf_o   = res_q.ovf;

   // Index fields are sized for the largest configuration; upper bits are idle here.
   assign unused_s = ^{pick_s.idx, res_q.id};

endmodule

// File: tb/tb_abs_share_arbiter.sv
module tb_abs_share_arbiter;

   localparam int N = 4;

`ifdef ABS_SHARE_SAT_EN
   localparam logic        SAT     = 1'b1;
   localparam logic [31:0] MIN_RES = 32'h7FFF_FFFF;
`else
   localparam logic        SAT     = 1'b0;
   localparam logic [31:0] MIN_RES = 32'h8000_0000;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic [N-1:0]  req_valid;
   logic [N*32-1:0] req_data;
   logic [N-1:0]  req_ready;
   logic          res_valid;
   logic          res_ready;
   logic [31:0]   res_data;
   logic [1:0]    res_id;
   logic          res_ovf;

   int total = 0;
   int bad   = 0;

   // reference model state
   int          m_ptr;
   logic        m_valid;
   logic [31:0] m_data;
   int          m_id;
   logic        m_ovf;

   always #5 clk = ~clk;

   abs_share_arbiter #(.NUM_REQ(N), .DW(32)) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid_i (req_valid),
      .req_data_i  (req_data),
      .req_ready_o (req_ready),
      .res_valid_o (res_valid),
      .res_ready_i (res_ready),
      .res_data_o  (res_data),
      .res_id_o    (res_id),
      .res_ovf_o   (res_ovf)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] m_abs(input logic [31:0] x);
      longint s;
      s = longint'(signed'(x));
      if (s < 0) s = -s;
      if (SAT && x == 32'h8000_0000) return 32'h7FFF_FFFF;
      return s[31:0];
   endfunction

   function automatic int m_winner(input logic [N-1:0] v, input logic rdy);
      if (m_valid && !rdy) return -1;
      for (int i = 0; i < N; i++) begin
         if (v[(m_ptr + i) % N]) return (m_ptr + i) % N;
      end
      return -1;
   endfunction

   task automatic m_reset();
      m_ptr = 0; m_valid = 1'b0; m_data = 32'h0; m_id = 0; m_ovf = 1'b0;
   endtask

   task automatic check_res(input string tag);
      chk({tag, ".res_valid"}, {31'b0, res_valid}, {31'b0, m_valid});
      chk({tag, ".res_data"},  res_data, m_data);
      chk({tag, ".res_id"},    {30'b0, res_id}, 32'(m_id));
      chk({tag, ".res_ovf"},   {31'b0, res_ovf}, {31'b0, m_ovf});
   endtask

   // One clock cycle: called and returns at a falling edge.
   task automatic cycle(input logic [N-1:0] v, input logic [N*32-1:0] d, input logic rdy);
      int g;
      logic [N-1:0] exp_rdy;
      logic [31:0] op;
      req_valid = v; req_data = d; res_ready = rdy;
      #1;
      g = m_winner(v, rdy);
      exp_rdy = (g >= 0) ? N'(1) << g : '0;
      chk("req_ready", {28'b0, req_ready}, {28'b0, exp_rdy});
      @(posedge clk);
      if (g >= 0) begin
         op      = d[g*32 +: 32];
         m_data  = m_abs(op);
         m_ovf   = (op == 32'h8000_0000);
         m_id    = g;
         m_valid = 1'b1;
         m_ptr   = (g + 1) % N;
      end else if (m_valid && rdy) begin
         m_valid = 1'b0;
      end
      #1;
      check_res("cyc");
      @(negedge clk);
   endtask

   function automatic logic [N*32-1:0] pack(input logic [31:0] a, input logic [31:0] b,
                                             input logic [31:0] c, input logic [31:0] e);
      return {e, c, b, a};
   endfunction

   typedef struct {
      logic [31:0] x;
      logic [31:0] y;
      logic        ovf;
   } abs_vec_t;

   abs_vec_t vecs[8];

   initial begin
      logic [N*32-1:0] d;
      logic [1:0] held_id;
      logic [31:0] held_data;

      vecs[0] = '{32'h0000_0000, 32'h0000_0000, 1'b0};
      vecs[1] = '{32'h0000_0001, 32'h0000_0001, 1'b0};
      vecs[2] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0};
      vecs[3] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0};
      vecs[4] = '{32'h8000_0000, MIN_RES,       1'b1};
      vecs[5] = '{32'h8000_0001, 32'h7FFF_FFFF, 1'b0};
      vecs[6] = '{32'hFFFF_FFFB, 32'h0000_0005, 1'b0};
      vecs[7] = '{32'h1234_5678, 32'h1234_5678, 1'b0};

      rst = 1'b1; req_valid = '1; req_data = '0; res_ready = 1'b1;
      m_reset();
      #2;
      chk("reset.req_ready", {28'b0, req_ready}, 32'h0);
      chk("reset.res_valid", {31'b0, res_valid}, 32'h0);
      chk("reset.res_data",  res_data, 32'h0);
      chk("reset.res_id",    {30'b0, res_id}, 32'h0);
      chk("reset.res_ovf",   {31'b0, res_ovf}, 32'h0);
      @(negedge clk); @(negedge clk);
      rst = 1'b0;

      // fairness: all valid, consumer always ready
      d = pack(32'hFFFF_FFF0, 32'h0000_0011, 32'hFFFF_FFEE, 32'h0000_0033);
      for (int i = 0; i < 8; i++) begin
         cycle(4'b1111, d, 1'b1);
         chk("fair.id",    {30'b0, res_id}, 32'(i % 4));
         chk("fair.valid", {31'b0, res_valid}, 32'h1);
      end
      cycle(4'b0000, d, 1'b1);
      chk("drain.valid", {31'b0, res_valid}, 32'h0);
      chk("drain.hold",  res_data, 32'h0000_0033);

      // single requester 2 sends -5
      cycle(4'b0100, pack(32'h0, 32'h0, 32'hFFFF_FFFB, 32'h0), 1'b1);
      chk("single.data", res_data, 32'h0000_0005);
      chk("single.id",   {30'b0, res_id}, 32'h2);
      chk("single.ovf",  {31'b0, res_ovf}, 32'h0);

      // ptr=3, only requester 1 valid, then 1 and 2 valid
      d = pack(32'h1, 32'hFFFF_FFF9, 32'h0000_0009, 32'h3);
      cycle(4'b0010, d, 1'b1);
      chk("wrap.id1", {30'b0, res_id}, 32'h1);
      chk("wrap.data1", res_data, 32'h0000_0007);
      cycle(4'b0110, d, 1'b1);
      chk("wrap.id2", {30'b0, res_id}, 32'h2);

      // backpressure: result pending, consumer stalled
      held_id = res_id; held_data = res_data;
      for (int i = 0; i < 5; i++) begin
         cycle(4'b1111, d, 1'b0);
         chk("bp.ready", {28'b0, req_ready}, 32'h0);
         chk("bp.id",    {30'b0, res_id}, {30'b0, held_id});
         chk("bp.data",  res_data, held_data);
      end
      cycle(4'b1111, d, 1'b1);
      chk("bp.next", {30'b0, res_id}, 32'((held_id + 1) % 4));

      // absolute-value table through requester 0
      foreach (vecs[i]) begin
         cycle(4'b0001, {96'b0, vecs[i].x}, 1'b1);
         chk("tbl.data", res_data, vecs[i].y);
         chk("tbl.ovf",  {31'b0, res_ovf}, {31'b0, vecs[i].ovf});
      end

      // randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         logic [31:0] w[4];
         for (int k = 0; k < 4; k++) begin
            case ($urandom_range(0, 5))
               0:       w[k] = 32'h8000_0000;
               1:       w[k] = 32'h0;
               2:       w[k] = 32'hFFFF_FFFF;
               default: w[k] = $urandom;
            endcase
         end
         cycle(4'($urandom), pack(w[0], w[1], w[2], w[3]), ($urandom_range(0, 3) != 0));
      end

      // asynchronous reset with a result pending
      d = pack(32'h5, 32'hFFFF_FFFE, 32'h7, 32'h8);
      cycle(4'b1111, d, 1'b1);
      chk("arst.pre", {31'b0, res_valid}, 32'h1);
      #2;
      rst = 1'b1;
      #1;
      chk("arst.valid", {31'b0, res_valid}, 32'h0);
      chk("arst.ready", {28'b0, req_ready}, 32'h0);
      m_reset();
      @(negedge clk); @(negedge clk);
      rst = 1'b0;
      cycle(4'b1010, d, 1'b1);
      chk("arst.first", {30'b0, res_id}, 32'h1);
      chk("arst.data",  res_data, 32'h0000_0002);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
